// File: rtl/panel_load_sequencer_pkg.sv
// rtl/panel_load_sequencer_pkg.sv - shared state type, constants and phase helper for the panel loader
package panel_load_sequencer_pkg;

  localparam logic [11:0] DEFAULT_START_PC = 12'o0200;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_LPC_SET,
    S_LPC_PRS,
    S_LPC_REL,
    S_DEP_SET,
    S_DEP_PRS,
    S_DEP_REL,
    S_PC_SET,
    S_PC_PRS,
    S_PC_REL,
    S_RUN,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } panel_seq_state_t;

  // Fixed successor of each timed phase; DEP_REL branches and is handled by the FSM itself.
  function automatic panel_seq_state_t next_phase(panel_seq_state_t s);
    case (s)
      S_LPC_SET: return S_LPC_PRS;
      S_LPC_PRS: return S_LPC_REL;
      S_LPC_REL: return S_DEP_SET;
      S_DEP_SET: return S_DEP_PRS;
      S_DEP_PRS: return S_DEP_REL;
      S_PC_SET:  return S_PC_PRS;
      S_PC_PRS:  return S_PC_REL;
      S_PC_REL:  return S_RUN;
      default:   return s;
    endcase
  endfunction

endpackage

// File: rtl/panel_load_sequencer_if.sv
// rtl/panel_load_sequencer_if.sv - host word stream, control and front-panel signal bundle
interface panel_load_sequencer_if #(
  parameter int WORD_W = 12,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              wr_last;
  logic [ADDR_W-1:0] start_pc;
  logic              start;
  logic              abort;
  logic              run_led;
  logic [WORD_W-1:0] sw_data;
  logic              run_sw;
  logic              load_pc_btn;
  logic              deposit_btn;
  logic              busy;
  logic              prog_done;
  logic [CNT_W-1:0]  words_loaded;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_last, start_pc, start, abort, run_led,
    input  wr_ready, sw_data, run_sw, load_pc_btn, deposit_btn, busy, prog_done, words_loaded
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_last, start_pc, start, abort, run_led,
    output wr_ready, sw_data, run_sw, load_pc_btn, deposit_btn, busy, prog_done, words_loaded
  );
endinterface

// File: rtl/panel_load_sequencer_fifo.sv
// rtl/panel_load_sequencer_fifo.sv - show-ahead synchronous FIFO holding {last,addr,data} image words
module panel_word_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wr_data,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push && !full)  wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop  && !empty) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
endmodule

// File: rtl/panel_load_sequencer.sv
// rtl/panel_load_sequencer.sv - replays queued (addr,data) words as Load-PC/Deposit presses, then runs
module panel_load_sequencer
  import panel_load_sequencer_pkg::*;
#(
  parameter int WORD_W   = 12,
  parameter int ADDR_W   = 12,
  parameter int DEPTH    = 16,
  parameter int HOLD     = 10,
  parameter int AUTO_INC = 1,
  parameter int CNT_W    = 16
) (
  input logic                  clock,
  input logic                  resetN,
  panel_load_sequencer_if.slave bus
);
  localparam int FW = 1 + ADDR_W + WORD_W;
  localparam int PW = $clog2(HOLD + 1);
  localparam logic [PW-1:0]     HOLD_LAST = PW'(HOLD - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  panel_seq_state_t  state_q;
  panel_seq_state_t  nxt_phase;
  logic [PW-1:0]     phase_q;
  logic [ADDR_W-1:0] cur_addr_q, prev_addr_q;
  logic [WORD_W-1:0] cur_data_q, sw_data_q;
  logic              cur_last_q, prev_valid_q;
  logic              run_sw_q, lpc_q, dep_q, busy_q, done_q;
  logic [CNT_W-1:0]  words_q, words_d;

  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [FW-1:0]     fifo_wr, fifo_rd;
  logic [ADDR_W-1:0] hd_addr;
  logic [WORD_W-1:0] hd_data;
  logic              phase_end, consecutive;

  assign fifo_wr   = {bus.wr_last, bus.wr_addr, bus.wr_data};
  assign hd_addr   = fifo_rd[WORD_W +: ADDR_W];
  assign hd_data   = fifo_rd[WORD_W-1:0];
  assign fifo_push = bus.wr_valid && !fifo_full && !bus.abort;
  assign fifo_pop  = (state_q == S_FETCH) && !fifo_empty && !bus.abort;

  assign phase_end   = (phase_q == HOLD_LAST);
  assign nxt_phase   = next_phase(state_q);
  // prev+1 wraps naturally at ADDR_W bits, matching the panel's PC rollover.
  assign consecutive = (AUTO_INC != 0) && prev_valid_q && (hd_addr == prev_addr_q + ADDR_ONE);
  assign words_d     = (&words_q) ? words_q : words_q + CNT_W'(1);

  panel_word_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetN  (resetN),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .flush   (bus.abort),
    .wr_data (fifo_wr),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      cur_addr_q   <= '0;
      cur_data_q   <= '0;
      cur_last_q   <= 1'b0;
      prev_addr_q  <= '0;
      prev_valid_q <= 1'b0;
      sw_data_q    <= '0;
      run_sw_q     <= 1'b0;
      lpc_q        <= 1'b0;
      dep_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      words_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q  <= S_IDLE;
        phase_q  <= '0;
        lpc_q    <= 1'b0;
        dep_q    <= 1'b0;
        run_sw_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE: begin
            if (bus.start) begin
              state_q      <= S_FETCH;
              busy_q       <= 1'b1;
              run_sw_q     <= 1'b0;
              words_q      <= '0;
              prev_valid_q <= 1'b0;
            end
          end
          S_FETCH: begin
            if (!fifo_empty) begin
              cur_last_q <= fifo_rd[FW-1];
              cur_addr_q <= hd_addr;
              cur_data_q <= hd_data;
              phase_q    <= '0;
              if (consecutive) begin
                state_q   <= S_DEP_SET;
                sw_data_q <= hd_data;
              end else begin
                state_q   <= S_LPC_SET;
                sw_data_q <= WORD_W'(hd_addr);
              end
            end
          end
          S_LPC_SET, S_LPC_PRS, S_LPC_REL, S_DEP_SET, S_DEP_PRS,
          S_PC_SET, S_PC_PRS, S_PC_REL: begin
            if (phase_end) begin
              phase_q <= '0;
              state_q <= nxt_phase;
              case (nxt_phase)
                S_LPC_PRS, S_PC_PRS: lpc_q     <= 1'b1;
                S_LPC_REL, S_PC_REL: lpc_q     <= 1'b0;
                S_DEP_SET:           sw_data_q <= cur_data_q;
                S_DEP_PRS:           dep_q     <= 1'b1;
                S_DEP_REL:           dep_q     <= 1'b0;
                S_RUN:               run_sw_q  <= 1'b1;
                default: ;
              endcase
            end else begin
              phase_q <= phase_q + PW'(1);
            end
          end
          S_DEP_REL: begin
            if (phase_end) begin
              phase_q      <= '0;
              words_q      <= words_d;
              prev_addr_q  <= cur_addr_q;
              prev_valid_q <= 1'b1;
              if (cur_last_q) begin
                state_q   <= S_PC_SET;
                sw_data_q <= WORD_W'(bus.start_pc);
              end else begin
                state_q <= S_FETCH;
              end
            end else begin
              phase_q <= phase_q + PW'(1);
            end
          end
          S_RUN:     state_q <= S_WAIT_HI;
          S_WAIT_HI: if (bus.run_led) state_q <= S_WAIT_LO;
          S_WAIT_LO: begin
            if (!bus.run_led) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_ready     = !fifo_full;
  assign bus.sw_data      = sw_data_q;
  assign bus.run_sw       = run_sw_q;
  assign bus.load_pc_btn  = lpc_q;
  assign bus.deposit_btn  = dep_q;
  assign bus.busy         = busy_q;
  assign bus.prog_done    = done_q;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_panel_load_sequencer.sv
// tb/tb_panel_load_sequencer.sv - scoreboard bench: image model predicts panel press events
module tb_panel_load_sequencer;
  import panel_load_sequencer_pkg::*;

  localparam int HOLD  = 10;
  localparam int CNT_W = 3;
  localparam int DEPTH = 16;
  localparam int EV_LPC = 0, EV_DEP = 1, EV_RUN = 2, EV_DONE = 3;

  typedef struct { int kind; int val; } ev_t;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  panel_load_sequencer_if #(.WORD_W(12), .ADDR_W(12), .CNT_W(CNT_W)) bus ();

  panel_load_sequencer #(
    .WORD_W(12), .ADDR_W(12), .DEPTH(DEPTH), .HOLD(HOLD), .AUTO_INC(1), .CNT_W(CNT_W)
  ) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  ev_t exp_q[$];
  int  img_a[$];
  int  img_d[$];
  int  vectors = 0;
  int  miscompares = 0;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input int val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Reference: a word needs Load-PC unless it directly follows the previous deposit address.
  task automatic expect_image(input int spc);
    int prev = -1;
    for (int i = 0; i < img_a.size(); i++) begin
      if (!(prev >= 0 && img_a[i] == ((prev + 1) % 4096))) push_ev(EV_LPC, img_a[i]);
      push_ev(EV_DEP, img_d[i]);
      prev = img_a[i];
    end
    push_ev(EV_LPC, spc);
    push_ev(EV_RUN, spc);
    push_ev(EV_DONE, (img_a.size() > 7) ? 7 : img_a.size());
  endtask

  task automatic add_word(input int a, input int d);
    img_a.push_back(a);
    img_d.push_back(d);
  endtask

  function automatic int sig(input int sel);
    case (sel)
      0:       return int'(bus.load_pc_btn);
      1:       return int'(bus.deposit_btn);
      2:       return int'(bus.run_sw);
      3:       return int'(bus.busy);
      4:       return int'(bus.prog_done);
      default: return int'(bus.wr_ready);
    endcase
  endfunction

  task automatic wait_sig(input string name, input int sel, input int level, input int budget);
    int hit = 0;
    for (int i = 0; i < budget && hit == 0; i++) begin
      @(negedge clock);
      if (sig(sel) == level) hit = 1;
    end
    check(name, hit, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_word(input int a, input int d, input bit last);
    bit acc = 1'b0;
    int t = 0;
    bus.wr_addr  = 12'(a);
    bus.wr_data  = 12'(d);
    bus.wr_last  = last;
    bus.wr_valid = 1'b1;
    while (!acc && t < 3000) begin
      @(negedge clock);
      acc = bus.wr_ready;
      @(posedge clock);
      #1;
      t++;
    end
    bus.wr_valid = 1'b0;
    if (!acc) check("push_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    idle(1);
    bus.start = 1'b0;
  endtask

  task automatic finish_run();
    wait_sig("run_sw_rise", 2, 1, 4000);
    idle($urandom_range(1, 8));
    bus.run_led = 1'b1;
    idle($urandom_range(1, 8));
    bus.run_led = 1'b0;
    wait_sig("busy_fall", 3, 0, 50);
    idle(1);
    check("queue_drained", exp_q.size(), 0);
    check("run_sw_in_done", int'(bus.run_sw), 1);
    exp_q.delete();
  endtask

  task automatic run_image(input int spc, input bit start_first);
    bus.start_pc = 12'(spc);
    expect_image(spc);
    if (start_first) pulse_start();
    for (int i = 0; i < img_a.size(); i++) begin
      push_word(img_a[i], img_d[i], i == img_a.size() - 1);
      idle($urandom_range(0, 3));
    end
    if (!start_first) pulse_start();
    finish_run();
  endtask

  task automatic random_image(input int n);
    int a = $urandom_range(0, 4095);
    img_a.delete();
    img_d.delete();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) a = (a + 1) % 4096;
      else a = $urandom_range(0, 4095);
      add_word(a, $urandom_range(0, 4095));
    end
  endtask

  // Monitor: turns button/run edges into events and checks press timing against HOLD.
  initial begin
    int  cyc = 0, chg_cyc = 0, rise_cyc = 0, fall_cyc = 0;
    bit  rel_pend = 1'b0, ab_flag = 1'b0;
    logic lpc_p = 1'b0, dep_p = 1'b0, run_p = 1'b0, done_p = 1'b0;
    logic [11:0] sw_p = '0;
    ev_t e;
    int  kind, val;
    bit  ev;
    forever begin
      @(negedge clock);
      if (!resetN) begin
        lpc_p = 1'b0; dep_p = 1'b0; run_p = 1'b0; done_p = 1'b0;
        sw_p = '0; rel_pend = 1'b0; ab_flag = 1'b0; chg_cyc = cyc;
      end else begin
        cyc++;
        ev = 1'b0;
        if (bus.load_pc_btn && bus.deposit_btn) check("both_buttons", 1, 0);
        if (bus.sw_data !== sw_p) begin
          if (rel_pend) check("sw_hold_after_release", int'(cyc - fall_cyc >= HOLD), 1);
          rel_pend = 1'b0;
          chg_cyc = cyc;
        end
        if ((bus.load_pc_btn || bus.deposit_btn) && bus.abort) ab_flag = 1'b1;
        if ((bus.load_pc_btn && !lpc_p) || (bus.deposit_btn && !dep_p)) begin
          check("sw_setup", int'(cyc - chg_cyc >= HOLD), 1);
          rise_cyc = cyc;
          ev = 1'b1; kind = bus.load_pc_btn ? EV_LPC : EV_DEP; val = int'(bus.sw_data);
        end
        if ((!bus.load_pc_btn && lpc_p) || (!bus.deposit_btn && dep_p)) begin
          if (!ab_flag) check("press_width", cyc - rise_cyc, HOLD);
          ab_flag = 1'b0;
          fall_cyc = cyc;
          rel_pend = 1'b1;
        end
        if (bus.run_sw && !run_p) begin
          ev = 1'b1; kind = EV_RUN; val = int'(bus.sw_data);
        end
        if (bus.prog_done) begin
          if (done_p) check("prog_done_single", 0, 1);
          else begin ev = 1'b1; kind = EV_DONE; val = int'(bus.words_loaded); end
        end
        if (ev) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d value %0o, expected none", kind, val);
          end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
              miscompares++;
              $display("FAIL event: got kind %0d value %0o, expected kind %0d value %0o",
                       kind, val, e.kind, e.val);
            end
          end
        end
        lpc_p = bus.load_pc_btn; dep_p = bus.deposit_btn; run_p = bus.run_sw;
        done_p = bus.prog_done; sw_p = bus.sw_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.run_led = 1'b0; bus.start_pc = DEFAULT_START_PC;
    idle(3);
    check("reset_sw_data", int'(bus.sw_data), 0);
    check("reset_run_sw", int'(bus.run_sw), 0);
    check("reset_buttons", int'(bus.load_pc_btn | bus.deposit_btn), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_prog_done", int'(bus.prog_done), 0);
    check("reset_words", int'(bus.words_loaded), 0);
    check("reset_wr_ready", int'(bus.wr_ready), 1);
    resetN = 1'b1;
    idle(1);

    img_a.delete(); img_d.delete();
    add_word(12'o0200, 12'o7200); add_word(12'o0201, 12'o1234);
    run_image(DEFAULT_START_PC, 1'b0);

    img_a.delete(); img_d.delete();
    add_word(12'o7777, 12'o0001); add_word(12'o0000, 12'o0002);
    run_image($urandom_range(0, 4095), 1'b1);

    img_a.delete(); img_d.delete();
    add_word(12'o0100, 12'o0011); add_word(12'o0300, 12'o0022);
    run_image($urandom_range(0, 4095), 1'b1);

    img_a.delete(); img_d.delete();
    for (int i = 0; i < DEPTH; i++) add_word(12'o0400 + i, $urandom_range(0, 4095));
    bus.start_pc = 12'o0400;
    expect_image(12'o0400);
    for (int i = 0; i < DEPTH; i++) push_word(img_a[i], img_d[i], i == DEPTH - 1);
    @(negedge clock);
    check("wr_ready_when_full", int'(bus.wr_ready), 0);
    @(posedge clock); #1;
    bus.wr_addr = 12'o7000; bus.wr_data = 12'o7000; bus.wr_last = 1'b1; bus.wr_valid = 1'b1;
    idle(1);
    bus.wr_valid = 1'b0;
    pulse_start();
    wait_sig("wr_ready_after_pop", 5, 1, 10);
    @(posedge clock); #1;
    finish_run();

    for (int k = 0; k < 6; k++) begin
      random_image($urandom_range(1, 10));
      run_image($urandom_range(0, 4095), k[0]);
    end

    push_ev(EV_LPC, 12'o1000); push_ev(EV_DEP, 12'o0055);
    pulse_start();
    push_word(12'o1000, 12'o0055, 1'b0);
    push_word(12'o2000, 12'o0066, 1'b0);
    push_word(12'o3000, 12'o0077, 1'b1);
    wait_sig("dep_press_seen", 1, 1, 200);
    @(posedge clock); #1;
    bus.abort = 1'b1;
    idle(1);
    bus.abort = 1'b0;
    check("abort_deposit_btn", int'(bus.deposit_btn), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_run_sw", int'(bus.run_sw), 0);
    check("abort_words_kept", int'(bus.words_loaded), 0);
    check("abort_queue", exp_q.size(), 0);
    exp_q.delete();

    pulse_start();
    idle(5 * HOLD);
    check("empty_fifo_waits", int'(bus.busy), 1);
    bus.wr_addr = 12'o4321; bus.wr_data = 12'o1111; bus.wr_last = 1'b1;
    bus.wr_valid = 1'b1; bus.abort = 1'b1;
    idle(1);
    bus.wr_valid = 1'b0; bus.abort = 1'b0;
    check("abort2_busy", int'(bus.busy), 0);
    pulse_start();
    idle(5 * HOLD);
    check("write_with_abort_dropped", int'(bus.busy), 1);
    bus.abort = 1'b1;
    idle(1);
    bus.abort = 1'b0;
    bus.start = 1'b1; bus.abort = 1'b1;
    idle(1);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_abort_wins", int'(bus.busy), 0);

    push_ev(EV_LPC, 12'o0500);
    pulse_start();
    push_word(12'o0500, 12'o0123, 1'b1);
    wait_sig("lpc_press_seen", 0, 1, 200);
    @(posedge clock); #3;
    resetN = 1'b0;
    #1;
    check("async_rst_sw_data", int'(bus.sw_data), 0);
    check("async_rst_lpc", int'(bus.load_pc_btn), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_run_sw", int'(bus.run_sw), 0);
    check("async_rst_words", int'(bus.words_loaded), 0);
    exp_q.delete();
    @(posedge clock); #1;
    resetN = 1'b1;
    idle(2);

    random_image($urandom_range(2, 9));
    run_image($urandom_range(0, 4095), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
